// File: rtl/sram_slave_ctrl.sv
// Responder for the sram_interface request/ok protocol. Drives an asynchronous
// 32-bit SRAM with programmable read/write wait states and byte-lane enables.
module sram_slave_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [31:0]       s_addr,
  input  logic [1:0]        s_mem_type,
  input  logic [31:0]       s_dout,
  output logic              s_ok,
  output logic [31:0]       s_din,
  output logic              s_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [2:0] {
    StIdle, StRead, StWrSetup, StWrPulse, StWrHold, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lo_q, lo_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        be_q, be_d;
  logic              err_q, err_d;
  logic              ok_q, ok_d;
  logic              serr_q, serr_d;

  logic              req_illegal;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_extract;

  // Request decode, evaluated on the live request fields in IDLE
  always_comb begin
    req_illegal = (s_mem_type == 2'd3) ||
                  ((s_mem_type == 2'd1) && s_addr[0]) ||
                  ((s_mem_type == 2'd2) && (s_addr[1:0] != 2'b00));
    req_be    = 4'hF;
    req_wdata = s_dout;
    case (s_mem_type)
      2'd0: begin
        req_be    = ~(4'b0001 << s_addr[1:0]);
        req_wdata = {4{s_dout[7:0]}};
      end
      2'd1: begin
        req_be    = s_addr[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{s_dout[15:0]}};
      end
      2'd2:    req_be = 4'h0;
      default: req_be = 4'hF;
    endcase
  end

  // Lane extraction; a legal half access always has lo_q[0] == 0
  always_comb begin
    rd_shift   = sram_rdata >> {lo_q, 3'b000};
    rd_extract = sram_rdata;
    case (type_q)
      2'd0:    rd_extract = {24'h0, rd_shift[7:0]};
      2'd1:    rd_extract = {16'h0, rd_shift[15:0]};
      default: rd_extract = sram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    be_d    = be_q;
    err_d   = err_q;
    ok_d    = 1'b0;
    serr_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (s_req) begin
          addr_d  = s_addr[ADDR_W+1:2];
          lo_d    = s_addr[1:0];
          type_d  = s_mem_type;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_illegal;
          cnt_d   = 8'd0;
          if (req_illegal) begin
            state_d = StDone;
            ok_d    = 1'b1;
            serr_d  = 1'b1;
          end else if (s_we) begin
            state_d = StWrSetup;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == 8'(READ_WAIT - 1)) begin
          din_d   = rd_extract;
          state_d = StDone;
          ok_d    = 1'b1;
          serr_d  = err_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = 8'd0;
      end
      StWrPulse: begin
        if (cnt_q == 8'(WRITE_WAIT - 1)) state_d = StWrHold;
        else                             cnt_d   = cnt_q + 8'd1;
      end
      StWrHold: begin
        state_d = StDone;
        ok_d    = 1'b1;
        serr_d  = err_q;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      lo_q    <= 2'b00;
      type_q  <= 2'b00;
      wdata_q <= 32'h0;
      din_q   <= 32'h0;
      be_q    <= 4'hF;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      be_q    <= be_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      serr_q  <= serr_d;
    end
  end

  // Strobes decode straight from the state register so reset releases them at once
  logic in_write;
  always_comb begin
    in_write     = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);
    sram_ce_n    = ~(in_write || (state_q == StRead));
    sram_oe_n    = ~(state_q == StRead);
    sram_we_n    = ~(state_q == StWrPulse);
    sram_data_oe = in_write;
    sram_be_n    = 4'hF;
    if (state_q == StRead) sram_be_n = 4'h0;
    else if (in_write)     sram_be_n = be_q;
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign s_ok       = ok_q;
  assign s_err      = serr_q;
  assign s_din      = din_q;

endmodule

// File: doc/sram_slave_ctrl.md
Name: sram_slave_ctrl

Overview:
- Responder end of the sram_interface read/write protocol: accepts one request at a time from a cache master.
- Drives an asynchronous 32-bit external SRAM with programmable wait states and byte-lane control.
- Returns a one-cycle completion pulse and lane-aligned read data.
- One instance sits behind each cache port, between the cache and the board SRAM pins.

Parameters:
- ADDR_W, 20: external SRAM word-address width; byte address bits [ADDR_W+1:2] are used.
- READ_WAIT, 2: cycles oe_n is held low before read data is sampled (>=1).
- WRITE_WAIT, 2: cycles we_n is held low (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_req  in  1  request valid (sram_interface.req)
- s_we  in  1  1 = write, 0 = read
- s_addr  in  32  byte address
- s_mem_type  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- s_dout  in  32  write data, right-aligned
- s_ok  out  1  completion pulse
- s_din  out  32  read data, right-aligned and zero-extended
- s_err  out  1  misaligned/illegal access flag, valid with s_ok
- sram_addr  out  ADDR_W  word address
- sram_wdata  out  32  lane-positioned write data
- sram_data_oe  out  1  data-pin output enable
- sram_rdata  in  32  data pins, input side
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  4  byte enables, active low, bit i = byte lane i

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - State IDLE; s_ok=0, s_err=0, s_din=0.
  - ce_n=oe_n=we_n=1, be_n=4'hF, data_oe=0, sram_addr=0, sram_wdata=0.
- Master contract: hold s_req and all request fields until s_ok. Any s_req seen in IDLE is a new request.
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - On s_req, latch addr, we, mem_type and dout, then decode.
  - Legal read -> READ. Legal write -> WR_SETUP. Illegal -> DONE with err=1 and no SRAM strobes.
  - Illegal means: mem_type 3, half with addr[0]=1, or word with addr[1:0]!=0.
- READ:
  - ce_n=0, oe_n=0, be_n=0000. Counter runs READ_WAIT cycles.
  - In the last cycle, sram_rdata is lane-extracted into s_din. Then -> DONE.
- WR_SETUP (1 cycle): ce_n=0, we_n=1, data_oe=1; addr, wdata and be_n are driven.
- WR_PULSE (WRITE_WAIT cycles): as WR_SETUP, but we_n=0.
- WR_HOLD (1 cycle): we_n=1, data and addr still driven. Then -> DONE.
- DONE (1 cycle): s_ok=1, s_err=latched error; all strobes inactive. Then -> IDLE.
- s_ok and s_err are registered. The earliest next acceptance is the cycle after DONE.
- Latency, counted from the IDLE acceptance edge:
  - Read: s_ok high READ_WAIT+1 cycles later.
  - Write: WRITE_WAIT+3 cycles later.
  - Error: 1 cycle later.
- Byte enables, active low (lanes enabled per type):
  - byte: lane addr[1:0] only.
  - half: lanes 1:0 if addr[1]=0, lanes 3:2 otherwise.
  - word: all four lanes.
- Write data: byte replicates dout[7:0] ×4; half replicates dout[15:0] ×2; word passes through.
- Read extract:
  - byte: zero-extended byte from lane addr[1:0].
  - half: zero-extended halfword from lanes {addr[1],1}:{addr[1],0}.
  - word: full 32 bits.
- s_din holds its value until the next successful read completes. Writes and errors leave it unchanged.
- sram_addr = latched addr[ADDR_W+1:2], held from acceptance until DONE. Upper address bits beyond ADDR_W+1 are ignored (wrap-around).
- A READ_WAIT/WRITE_WAIT counter reaching its terminal count always advances the state; no stall input exists.

Test Plan:
- Reset, then idle with s_req=0: all strobes high, be_n=F, s_ok never asserts.
- Word write 0xDEADBEEF @0x0000_0010, then word read @0x10:
  - Write: sram_addr=4, we_n low for 2 cycles, be_n=0, s_ok at cycle 5.
  - Read: s_ok at cycle 3, s_din=0xDEADBEEF.
- Byte write 0xA5 @0x13, then byte read @0x13:
  - Write: be_n=0111, wdata=0xA5A5A5A5.
  - Read: s_din=0x000000A5.
- Half read @0x12 with SRAM word 0x8001_7FFF: s_din=0x00008001. Same at @0x10: s_din=0x00007FFF.
- Misaligned word read @0x02 and mem_type=3: s_ok and s_err pulse at cycle 1, ce_n stays 1, s_din unchanged.
- Assert rst during WR_PULSE: we_n and ce_n go 1 in the same cycle without a clock edge; the following read request completes normally.
